ide_3f6_arbiter: RTL and testbench

Shares the single IDE device-control/alt-status port (I/O 0x3F6) between two requesters. Requester A is the CPU I/O path. Requester B is the management/HPS-side IDE emulation. Each requester presents a 3-bit offset within the 0x3F0 window. The block serialises accesses with round-robin fairness and issues one-cycle read/write strobes to the IDE shared port. It captures read data after a fixed latency and returns a one-cycle completion to the granted requester.

---
 rtl/ide_pkg.sv | 19 +
 rtl/ide_3f6_arbiter_if.sv | 21 ++
 rtl/ide_3f6_arbiter.sv | 154 +++++++++++++++
 tb/tb_ide_3f6_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ide_pkg.sv
// Shared types and constants for the IDE 0x3F6 port arbiter.
package ide_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   localparam logic [2:0] IDE_3F6_OFFSET = 3'd6;
   localparam logic [7:0] DEFAULT_RDATA  = 8'hFF;

endpackage

// File: rtl/ide_3f6_arbiter_if.sv
// One requester channel into the 0x3F6 arbiter: read/write held until done, readdata valid with done.
interface ide_3f6_arbiter_if;

   logic [2:0] address;
   logic       read;
   logic       write;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       done;

   modport master (
      output address, read, write, writedata,
      input  readdata, done
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata, done
   );

endinterface

// File: rtl/ide_3f6_arbiter.sv
// Round-robin share of the IDE 0x3F6 port between A and B; done 2 cycles after grant (2+READ_LATENCY for port reads).
// Requesters hold read/write until done; a losing requester simply waits in IDLE.
module ide_3f6_arbiter
   import ide_pkg::*;
#(
   parameter int         READ_LATENCY = 1,
   parameter logic [2:0] PORT_OFFSET  = IDE_3F6_OFFSET
) (
   input  logic             clk,
   input  logic             rst_n,
   ide_3f6_arbiter_if.slave a,
   ide_3f6_arbiter_if.slave b,
   output logic             busy,
   output logic             ide_3f6_read,
   input  logic [7:0]       ide_3f6_readdata,
   output logic             ide_3f6_write,
   output logic [7:0]       ide_3f6_writedata
);

   state_t     state, state_nxt;
   req_id_t    gnt, gnt_nxt;
   req_id_t    last_grant, last_grant_nxt;
   logic       op_wr, op_wr_nxt;
   logic [2:0] addr, addr_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [7:0] wdata_sel;
   logic       a_req, b_req;
   logic       rd_stb_nxt, wr_stb_nxt, busy_nxt;
   logic       a_done_nxt, b_done_nxt;
   logic [7:0] ide_wdata_nxt, a_rdata_nxt, b_rdata_nxt;

   // A wins ties unless it was served last.
   function automatic req_id_t rr_pick(input logic a_pend, input logic b_pend, input req_id_t last);
      if (a_pend && b_pend) return (last == REQ_A) ? REQ_B : REQ_A;
      else if (b_pend)      return REQ_B;
      else                  return REQ_A;
   endfunction

   assign a_req = a.read | a.write;
   assign b_req = b.read | b.write;

   always_comb begin
      state_nxt      = state;
      gnt_nxt        = gnt;
      last_grant_nxt = last_grant;
      op_wr_nxt      = op_wr;
      addr_nxt       = addr;
      cnt_nxt        = cnt;
      wdata_sel      = 8'h00;
      rd_stb_nxt     = 1'b0;
      wr_stb_nxt     = 1'b0;
      a_done_nxt     = 1'b0;
      b_done_nxt     = 1'b0;
      ide_wdata_nxt  = ide_3f6_writedata;
      a_rdata_nxt    = a.readdata;
      b_rdata_nxt    = b.readdata;

      case (state)
         IDLE: begin
            if (a_req || b_req) begin
               gnt_nxt = rr_pick(a_req, b_req, last_grant);
               if (gnt_nxt == REQ_A) begin
                  op_wr_nxt = a.write;
                  addr_nxt  = a.address;
                  wdata_sel = a.writedata;
               end else begin
                  op_wr_nxt = b.write;
                  addr_nxt  = b.address;
                  wdata_sel = b.writedata;
               end
               // Strobes are registered, so they are decided here to land in ISSUE.
               if (addr_nxt == PORT_OFFSET) begin
                  if (op_wr_nxt) begin
                     wr_stb_nxt    = 1'b1;
                     ide_wdata_nxt = wdata_sel;
                  end else begin
                     rd_stb_nxt = 1'b1;
                  end
               end
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (addr == PORT_OFFSET && !op_wr) begin
               cnt_nxt   = 3'(READ_LATENCY);
               state_nxt = WAIT;
            end else begin
               state_nxt = DONE;
               if (gnt == REQ_A) a_done_nxt = 1'b1;
               else              b_done_nxt = 1'b1;
               if (!op_wr) begin
                  if (gnt == REQ_A) a_rdata_nxt = DEFAULT_RDATA;
                  else              b_rdata_nxt = DEFAULT_RDATA;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) begin
               state_nxt = DONE;
               if (gnt == REQ_A) begin
                  a_done_nxt  = 1'b1;
                  a_rdata_nxt = ide_3f6_readdata;
               end else begin
                  b_done_nxt  = 1'b1;
                  b_rdata_nxt = ide_3f6_readdata;
               end
            end
         end
         DONE: begin
            last_grant_nxt = gnt;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         gnt               <= REQ_A;
         last_grant        <= REQ_B;
         op_wr             <= 1'b0;
         addr              <= 3'd0;
         cnt               <= 3'd0;
         busy              <= 1'b0;
         ide_3f6_read      <= 1'b0;
         ide_3f6_write     <= 1'b0;
         ide_3f6_writedata <= 8'h00;
         a.done            <= 1'b0;
         b.done            <= 1'b0;
         a.readdata        <= 8'h00;
         b.readdata        <= 8'h00;
      end else begin
         state             <= state_nxt;
         gnt               <= gnt_nxt;
         last_grant        <= last_grant_nxt;
         op_wr             <= op_wr_nxt;
         addr              <= addr_nxt;
         cnt               <= cnt_nxt;
         busy              <= busy_nxt;
         ide_3f6_read      <= rd_stb_nxt;
         ide_3f6_write     <= wr_stb_nxt;
         ide_3f6_writedata <= ide_wdata_nxt;
         a.done            <= a_done_nxt;
         b.done            <= b_done_nxt;
         a.readdata        <= a_rdata_nxt;
         b.readdata        <= b_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_ide_3f6_arbiter.sv
// Bench for ide_3f6_arbiter: two instances (READ_LATENCY 1 and 3) driven in lockstep, timeline model plus directed literals.
module tb_ide_3f6_arbiter;
   import ide_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [1:0][2:0] a_addr, b_addr;
   logic [1:0]      a_rd, a_wr, b_rd, b_wr;
   logic [1:0][7:0] a_wd, b_wd, a_rdo, b_rdo;
   logic [1:0]      a_dn, b_dn, busy, ird, iwr;
   logic [1:0][7:0] iwd, irdd;

   for (genvar d = 0; d < 2; d++) begin : g_dut
      ide_3f6_arbiter_if u_a ();
      ide_3f6_arbiter_if u_b ();
      assign u_a.address   = a_addr[d];
      assign u_a.read      = a_rd[d];
      assign u_a.write     = a_wr[d];
      assign u_a.writedata = a_wd[d];
      assign u_b.address   = b_addr[d];
      assign u_b.read      = b_rd[d];
      assign u_b.write     = b_wr[d];
      assign u_b.writedata = b_wd[d];
      assign a_rdo[d] = u_a.readdata;
      assign a_dn[d]  = u_a.done;
      assign b_rdo[d] = u_b.readdata;
      assign b_dn[d]  = u_b.done;
      ide_3f6_arbiter #(.READ_LATENCY(d == 0 ? 1 : 3)) u_dut (
         .clk               (clk),
         .rst_n             (rst_n),
         .a                 (u_a),
         .b                 (u_b),
         .busy              (busy[d]),
         .ide_3f6_read      (ird[d]),
         .ide_3f6_readdata  (irdd[d]),
         .ide_3f6_write     (iwr[d]),
         .ide_3f6_writedata (iwd[d])
      );
   end

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cyc, act, exp);
      end
   endtask

   task automatic lit(input string name, input int d, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
      end
   endtask

   // Timeline model: a grant at t=0, strobe at t=1, port-read sample at t=1+L, done at t=dur, IDLE at t=dur+1.
   logic [1:0]      m_valid = 2'b00;
   logic [1:0]      m_in, m_wr, m_port, m_gnt, m_last;
   logic [1:0][7:0] m_wdat, m_cap;
   int              m_t [2];
   int              m_dur [2];
   logic [1:0]      exp_busy, exp_rs, exp_ws, exp_ad, exp_bd;
   logic [1:0][7:0] exp_wd, exp_ard, exp_brd;

   task automatic model_step(input int d);
      logic ra, rb;
      logic [2:0] ad;
      exp_rs[d] = 1'b0; exp_ws[d] = 1'b0; exp_ad[d] = 1'b0; exp_bd[d] = 1'b0;
      if (!rst_n) begin
         m_valid[d] = 1'b1; m_in[d] = 1'b0; m_last[d] = 1'b1;
         exp_busy[d] = 1'b0; exp_wd[d] = 8'h00; exp_ard[d] = 8'h00; exp_brd[d] = 8'h00;
         return;
      end
      if (!m_valid[d]) return;
      if (!m_in[d]) begin
         ra = a_rd[d] | a_wr[d];
         rb = b_rd[d] | b_wr[d];
         exp_busy[d] = 1'b0;
         if (ra || rb) begin
            m_gnt[d]  = (ra && rb) ? ~m_last[d] : rb;
            m_wr[d]   = m_gnt[d] ? b_wr[d] : a_wr[d];
            ad        = m_gnt[d] ? b_addr[d] : a_addr[d];
            m_wdat[d] = m_gnt[d] ? b_wd[d] : a_wd[d];
            m_port[d] = (ad == IDE_3F6_OFFSET);
            m_dur[d]  = (m_port[d] && !m_wr[d]) ? 2 + lat(d) : 2;
            m_in[d]   = 1'b1;
            m_t[d]    = 1;
            exp_busy[d] = 1'b1;
            exp_rs[d] = m_port[d] & ~m_wr[d];
            exp_ws[d] = m_port[d] & m_wr[d];
            if (exp_ws[d]) exp_wd[d] = m_wdat[d];
         end
      end else begin
         if (m_port[d] && !m_wr[d] && m_t[d] == 1 + lat(d)) m_cap[d] = irdd[d];
         if (m_t[d] == m_dur[d]) begin
            m_in[d] = 1'b0; m_last[d] = m_gnt[d]; exp_busy[d] = 1'b0;
         end else begin
            m_t[d]++;
            exp_busy[d] = 1'b1;
            if (m_t[d] == m_dur[d]) begin
               if (m_gnt[d]) exp_bd[d] = 1'b1; else exp_ad[d] = 1'b1;
               if (!m_wr[d]) begin
                  if (m_gnt[d]) exp_brd[d] = m_port[d] ? m_cap[d] : 8'hFF;
                  else          exp_ard[d] = m_port[d] ? m_cap[d] : 8'hFF;
               end
            end
         end
      end
   endtask

   // Event log written only by the compare process.
   int         iwr_n [2], ird_n [2], an_n [2], bn_n [2];
   int         iwr_c [2], ird_c [2], an_c [2], bn_c [2];
   int         rd_stb_cyc [2] = '{-100, -100};
   logic [1:0][7:0] iwr_dat, an_dat, bn_dat;
   logic [1:0][3:0] first4;
   int         nrec [2];
   logic       rec_on = 1'b0;

   initial begin
      for (int d = 0; d < 2; d++) begin
         iwr_n[d] = 0; ird_n[d] = 0; an_n[d] = 0; bn_n[d] = 0; nrec[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (m_valid[d]) begin
               chk("busy",   d, 8'(busy[d]), 8'(exp_busy[d]));
               chk("rd_stb", d, 8'(ird[d]),  8'(exp_rs[d]));
               chk("wr_stb", d, 8'(iwr[d]),  8'(exp_ws[d]));
               chk("wdata",  d, iwd[d],      exp_wd[d]);
               chk("a_done", d, 8'(a_dn[d]), 8'(exp_ad[d]));
               chk("b_done", d, 8'(b_dn[d]), 8'(exp_bd[d]));
               chk("a_rdata", d, a_rdo[d],   exp_ard[d]);
               chk("b_rdata", d, b_rdo[d],   exp_brd[d]);
            end
            if (iwr[d]) begin iwr_n[d]++; iwr_c[d] = cyc; iwr_dat[d] = iwd[d]; end
            if (ird[d]) begin ird_n[d]++; ird_c[d] = cyc; rd_stb_cyc[d] = cyc; end
            if (a_dn[d]) begin an_n[d]++; an_c[d] = cyc; an_dat[d] = a_rdo[d]; end
            if (b_dn[d]) begin bn_n[d]++; bn_c[d] = cyc; bn_dat[d] = b_rdo[d]; end
            if (rec_on && nrec[d] < 4 && (a_dn[d] || b_dn[d])) begin
               first4[d][nrec[d]] = b_dn[d];
               nrec[d]++;
            end
            model_step(d);
         end
      end
   end

   // Stimulus, requester agents and IDE device all live in this one process.
   logic       hold_a = 1'b0, hold_b = 1'b0;
   logic [7:0] dev_val = 8'h00;
   int s_wr [2], s_rd [2], s_an [2], s_bn [2];
   int t0;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            if (a_dn[d] && !hold_a) begin a_rd[d] = 1'b0; a_wr[d] = 1'b0; end
            if (b_dn[d] && !hold_b) begin b_rd[d] = 1'b0; b_wr[d] = 1'b0; end
            irdd[d] = (cyc == rd_stb_cyc[d] + lat(d)) ? dev_val : {4'hE, cyc[3:0]};
         end
      end
   endtask

   task automatic set_a(input logic rd, input logic wr, input logic [2:0] ad, input logic [7:0] wd);
      for (int d = 0; d < 2; d++) begin
         a_rd[d] = rd; a_wr[d] = wr; a_addr[d] = ad; a_wd[d] = wd;
      end
   endtask

   task automatic set_b(input logic rd, input logic wr, input logic [2:0] ad, input logic [7:0] wd);
      for (int d = 0; d < 2; d++) begin
         b_rd[d] = rd; b_wr[d] = wr; b_addr[d] = ad; b_wd[d] = wd;
      end
   endtask

   task automatic snap();
      for (int d = 0; d < 2; d++) begin
         s_wr[d] = iwr_n[d]; s_rd[d] = ird_n[d]; s_an[d] = an_n[d]; s_bn[d] = bn_n[d];
      end
      t0 = cyc;
   endtask

   initial begin
      set_a(1'b0, 1'b0, 3'd0, 8'h00);
      set_b(1'b0, 1'b0, 3'd0, 8'h00);
      irdd = '0;
      tick(3);
      for (int d = 0; d < 2; d++) begin
         lit("reset_busy",  d, int'(busy[d]), 0);
         lit("reset_rdata", d, int'(a_rdo[d]) + int'(b_rdo[d]) + int'(iwd[d]), 0);
         lit("reset_stb",   d, int'(ird[d]) + int'(iwr[d]) + int'(a_dn[d]) + int'(b_dn[d]), 0);
      end
      rst_n = 1'b1;
      tick(1);

      // A writes 0x04 to the port.
      snap();
      set_a(1'b0, 1'b1, IDE_3F6_OFFSET, 8'h04);
      tick(6);
      for (int d = 0; d < 2; d++) begin
         lit("t1_wr_count", d, iwr_n[d] - s_wr[d], 1);
         lit("t1_wr_cycle", d, iwr_c[d] - t0, 1);
         lit("t1_wr_data",  d, int'(iwr_dat[d]), 8'h04);
         lit("t1_a_done",   d, an_c[d] - t0, 2);
         lit("t1_b_quiet",  d, bn_n[d] - s_bn[d], 0);
      end

      // B reads the port; device answers 0x50 READ_LATENCY after the strobe.
      snap();
      dev_val = 8'h50;
      set_b(1'b1, 1'b0, IDE_3F6_OFFSET, 8'h00);
      tick(8);
      for (int d = 0; d < 2; d++) begin
         lit("t2_rd_cycle", d, ird_c[d] - t0, 1);
         lit("t2_b_done",   d, bn_c[d] - t0, (d == 0) ? 3 : 5);
         lit("t2_b_data",   d, int'(bn_dat[d]), 8'h50);
         lit("t2_a_hold",   d, int'(a_rdo[d]), 8'h00);
      end

      // A reads a non-port offset.
      snap();
      set_a(1'b1, 1'b0, 3'd2, 8'h00);
      tick(6);
      for (int d = 0; d < 2; d++) begin
         lit("t3_no_stb", d, (iwr_n[d] - s_wr[d]) + (ird_n[d] - s_rd[d]), 0);
         lit("t3_a_done", d, an_c[d] - t0, 2);
         lit("t3_a_data", d, int'(an_dat[d]), 8'hFF);
         lit("t3_b_hold", d, int'(b_rdo[d]), 8'h50);
      end

      // Reset lands while both instances sit in WAIT.
      snap();
      dev_val = 8'h77;
      set_a(1'b1, 1'b0, IDE_3F6_OFFSET, 8'h00);
      tick(2);
      rst_n = 1'b0;
      set_a(1'b0, 1'b0, 3'd0, 8'h00);
      tick(1);
      for (int d = 0; d < 2; d++) begin
         lit("t5_busy",  d, int'(busy[d]), 0);
         lit("t5_rdata", d, int'(a_rdo[d]) + int'(b_rdo[d]), 0);
      end
      rst_n = 1'b1;
      tick(6);
      for (int d = 0; d < 2; d++) lit("t5_no_done", d, an_n[d] - s_an[d], 0);
      snap();
      set_a(1'b1, 1'b0, IDE_3F6_OFFSET, 8'h00);
      tick(8);
      for (int d = 0; d < 2; d++) begin
         lit("t5_fresh_done", d, an_c[d] - t0, (d == 0) ? 3 : 5);
         lit("t5_fresh_data", d, int'(an_dat[d]), 8'h77);
      end

      // Both request right after reset, then keep requesting: A, B, A, B.
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      dev_val = 8'h3C;
      hold_a = 1'b1; hold_b = 1'b1; rec_on = 1'b1;
      set_a(1'b1, 1'b0, IDE_3F6_OFFSET, 8'h00);
      set_b(1'b1, 1'b0, IDE_3F6_OFFSET, 8'h00);
      tick(40);
      hold_a = 1'b0; hold_b = 1'b0;
      set_a(1'b0, 1'b0, 3'd0, 8'h00);
      set_b(1'b0, 1'b0, 3'd0, 8'h00);
      tick(12);
      for (int d = 0; d < 2; d++) begin
         lit("t4_count", d, nrec[d], 4);
         lit("t4_order", d, int'(first4[d]), 4'b1010);
      end

      // read+write together is a write.
      snap();
      set_a(1'b1, 1'b1, IDE_3F6_OFFSET, 8'h9A);
      tick(6);
      for (int d = 0; d < 2; d++) begin
         lit("t6_wr_count", d, iwr_n[d] - s_wr[d], 1);
         lit("t6_rd_count", d, ird_n[d] - s_rd[d], 0);
         lit("t6_wr_data",  d, int'(iwr_dat[d]), 8'h9A);
         lit("t6_a_done",   d, an_c[d] - t0, 2);
      end
      snap();
      dev_val = 8'hC3;
      set_a(1'b1, 1'b0, IDE_3F6_OFFSET, 8'h00);
      tick(8);
      for (int d = 0; d < 2; d++) begin
         lit("t6_rd_cycle", d, ird_c[d] - t0, 1);
         lit("t6_rd_done",  d, an_c[d] - t0, (d == 0) ? 3 : 5);
         lit("t6_rd_data",  d, int'(an_dat[d]), 8'hC3);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
